// File: rtl/usb_fs_phy_rx_if.sv
// rtl/usb_fs_phy_rx_if.sv - receive byte stream from the FS PHY front end to the SIE
interface usb_fs_phy_rx_if;
    logic       rx_active;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       eop;

    modport master (output rx_active, rx_valid, rx_data, rx_err, eop);
    modport slave  (input  rx_active, rx_valid, rx_data, rx_err, eop);
endinterface

// File: rtl/usb_fs_phy_rx.sv
// rtl/usb_fs_phy_rx.sv - full-speed USB receive front end: sync, clock recovery, NRZI, unstuff, EOP
module usb_fs_phy_rx #(
    parameter int unsigned SYNC_MIN_TOGGLES  = 3,
    parameter int unsigned SYNC_TIMEOUT_BITS = 16,
    parameter int unsigned SAMPLE_PHASE      = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dp_i,
    input  logic            dm_i,
    input  logic            rx_en,
    output logic [1:0]      line_state,
    usb_fs_phy_rx_if.master rx
);
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ERR_WAIT
    } state_t;

    logic       dp_m, dp_s, dm_m, dm_s;
    logic [1:0] line;
    logic [1:0] line_d;
    logic [1:0] phase_q;
    logic [1:0] cur_phase;
    logic       sample;

    state_t     state, state_n;
    logic [1:0] prev_lvl, prev_n;
    logic [3:0] tog_cnt, tog_n;
    logic [7:0] tmo_cnt, tmo_n;
    logic [2:0] bit_cnt, bit_n;
    logic [2:0] ones_cnt, ones_n;
    logic [7:0] shreg, sh_n;
    logic       err_pend, pend_n;
    logic       seen_se0, seen_n;
    logic [7:0] rx_data_q, data_n;
    logic       rx_valid_q, valid_n;
    logic       rx_err_q, err_n;
    logic       eop_q, eop_n;
    logic       is_jk;
    logic       dbit;

    // Two-flop synchronisers; reset to idle J so no false edge is seen after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_m    <= 1'b1;
            dp_s    <= 1'b1;
            dm_m    <= 1'b0;
            dm_s    <= 1'b0;
            line_d  <= LS_J;
            phase_q <= 2'd0;
        end else begin
            dp_m    <= dp_i;
            dp_s    <= dp_m;
            dm_m    <= dm_i;
            dm_s    <= dm_m;
            line_d  <= line;
            phase_q <= cur_phase + 2'd1;
        end
    end

    assign line       = {dp_s, dm_s};
    assign line_state = line;
    // The edge cycle itself is phase 0, so the sample lands mid-bit even on short bits.
    assign cur_phase  = (line != line_d) ? 2'd0 : phase_q;
    assign sample     = (cur_phase == 2'(SAMPLE_PHASE));
    assign is_jk      = (line == LS_J) || (line == LS_K);
    assign dbit       = (line == prev_lvl);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            prev_lvl   <= LS_J;
            tog_cnt    <= '0;
            tmo_cnt    <= '0;
            bit_cnt    <= '0;
            ones_cnt   <= '0;
            shreg      <= '0;
            err_pend   <= 1'b0;
            seen_se0   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            eop_q      <= 1'b0;
        end else begin
            state      <= state_n;
            prev_lvl   <= prev_n;
            tog_cnt    <= tog_n;
            tmo_cnt    <= tmo_n;
            bit_cnt    <= bit_n;
            ones_cnt   <= ones_n;
            shreg      <= sh_n;
            err_pend   <= pend_n;
            seen_se0   <= seen_n;
            rx_data_q  <= data_n;
            rx_valid_q <= valid_n;
            rx_err_q   <= err_n;
            eop_q      <= eop_n;
        end
    end

    always_comb begin
        state_n = state;
        prev_n  = prev_lvl;
        tog_n   = tog_cnt;
        tmo_n   = tmo_cnt;
        bit_n   = bit_cnt;
        ones_n  = ones_cnt;
        sh_n    = shreg;
        pend_n  = err_pend;
        seen_n  = seen_se0;
        data_n  = rx_data_q;
        valid_n = 1'b0;
        err_n   = 1'b0;
        eop_n   = 1'b0;

        if (sample) begin
            prev_n = line;
        end

        if (!rx_en) begin
            state_n = ST_IDLE;
        end else if (sample) begin
            unique case (state)
                ST_IDLE: begin
                    if (line == LS_K) begin
                        state_n = ST_SYNC;
                        tog_n   = '0;
                        tmo_n   = '0;
                    end
                end

                ST_SYNC: begin
                    tmo_n = tmo_cnt + 8'd1;
                    if ((line == LS_K) && dbit) begin
                        if (32'(tog_cnt) >= SYNC_MIN_TOGGLES) begin
                            state_n = ST_DATA;
                            bit_n   = '0;
                            ones_n  = '0;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else if (!is_jk || dbit) begin
                        state_n = ST_IDLE;
                    end else begin
                        if (tog_cnt != 4'hF) begin
                            tog_n = tog_cnt + 4'd1;
                        end
                        if (32'(tmo_n) >= SYNC_TIMEOUT_BITS) begin
                            state_n = ST_IDLE;
                        end
                    end
                end

                ST_DATA: begin
                    if (line == LS_SE0) begin
                        state_n = ST_EOP;
                        pend_n  = (bit_cnt != 3'd0);
                        tmo_n   = 8'd1;
                    end else if (line == LS_SE1) begin
                        err_n   = 1'b1;
                        seen_n  = 1'b0;
                        state_n = ST_ERR_WAIT;
                    end else if (ones_cnt == 3'd6) begin
                        // Stuff bit slot: a 0 is discarded, a 1 is a stuffing violation.
                        if (dbit) begin
                            err_n   = 1'b1;
                            seen_n  = 1'b0;
                            state_n = ST_ERR_WAIT;
                        end else begin
                            ones_n = '0;
                        end
                    end else begin
                        sh_n   = {dbit, shreg[7:1]};
                        ones_n = dbit ? (ones_cnt + 3'd1) : 3'd0;
                        bit_n  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            data_n  = sh_n;
                            valid_n = 1'b1;
                        end
                    end
                end

                ST_EOP: begin
                    if (line == LS_SE0) begin
                        tmo_n = tmo_cnt + 8'd1;
                        // Ninth SE0 bit: this is a bus reset, not a packet end.
                        if (tmo_cnt >= 8'd8) begin
                            eop_n   = 1'b1;
                            state_n = ST_IDLE;
                        end
                    end else begin
                        eop_n   = 1'b1;
                        err_n   = err_pend;
                        state_n = ST_IDLE;
                    end
                end

                ST_ERR_WAIT: begin
                    if (line == LS_SE0) begin
                        seen_n = 1'b1;
                    end else if (seen_se0 && (line == LS_J)) begin
                        eop_n   = 1'b1;
                        state_n = ST_IDLE;
                    end
                end

                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign rx.rx_active = (state == ST_DATA) || (state == ST_EOP) || (state == ST_ERR_WAIT);
    assign rx.rx_valid  = rx_valid_q;
    assign rx.rx_data   = rx_data_q;
    assign rx.rx_err    = rx_err_q;
    assign rx.eop       = eop_q;
endmodule

// File: tb/tb_usb_fs_phy_rx.sv
// tb/tb_usb_fs_phy_rx.sv - randomized self-checking bench for usb_fs_phy_rx against a bit-list model
module tb_usb_fs_phy_rx;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    logic       clk = 1'b0;
    logic       rst;
    logic       dp;
    logic       dm;
    logic       rx_en;
    logic [1:0] line_state;

    usb_fs_phy_rx_if rxif ();

    usb_fs_phy_rx dut (
        .clk        (clk),
        .rst        (rst),
        .dp_i       (dp),
        .dm_i       (dm),
        .rx_en      (rx_en),
        .line_state (line_state),
        .rx         (rxif)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    int         n_valid = 0;
    int         n_err = 0;
    int         n_eop = 0;
    int         n_erreop = 0;
    int         n_act = 0;
    int         viol_ve = 0;
    int         viol_eop = 0;
    logic       prev_act = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (rxif.rx_valid === 1'b1) begin
            n_valid++;
            got_q.push_back(rxif.rx_data);
        end
        if (rxif.rx_err === 1'b1) n_err++;
        if (rxif.eop === 1'b1) begin
            n_eop++;
            if (rxif.rx_err === 1'b1) n_erreop++;
            if (rxif.rx_active !== 1'b0 || prev_act !== 1'b1) viol_eop++;
        end
        if (rxif.rx_valid === 1'b1 && rxif.eop === 1'b1) viol_ve++;
        if (rxif.rx_active === 1'b1) n_act++;
        prev_act = rxif.rx_active;
    end

    bit         lbits[$];
    bit         wbits[$];
    logic [7:0] exp_q[$];
    int         exp_err;
    int         exp_erreop;
    bit         jit_ph;

    task automatic add_byte(input logic [7:0] b);
        for (int k = 0; k < 8; k++) lbits.push_back(b[k]);
    endtask

    task automatic build(input bit stuff_en);
        int run;
        run = 0;
        wbits.delete();
        foreach (lbits[i]) begin
            wbits.push_back(lbits[i]);
            run = lbits[i] ? run + 1 : 0;
            if (stuff_en && run == 6) begin
                wbits.push_back(1'b0);
                run = 0;
            end
        end
    endtask

    // Expected receiver view of the wire bit list: drop stuff zeros, flag stuffing violations.
    task automatic model(input int se0_bits);
        int         run;
        int         nd;
        logic [7:0] cur;
        bit         serr;
        bit         mis;
        run  = 0;
        nd   = 0;
        cur  = '0;
        serr = 0;
        exp_q.delete();
        foreach (wbits[i]) begin
            if (!serr) begin
                if (run == 6) begin
                    if (wbits[i]) serr = 1;
                    else run = 0;
                end else begin
                    cur[nd[2:0]] = wbits[i];
                    nd++;
                    run = wbits[i] ? run + 1 : 0;
                    if (nd % 8 == 0) exp_q.push_back(cur);
                end
            end
        end
        mis        = !serr && (nd % 8 != 0) && (se0_bits <= 8);
        exp_err    = (serr || mis) ? 1 : 0;
        exp_erreop = mis ? 1 : 0;
    endtask

    task automatic put(input logic [1:0] l, input bit jit);
        int n;
        dp = l[1];
        dm = l[0];
        n  = 4;
        if (jit) begin
            n      = jit_ph ? 5 : 3;
            jit_ph = ~jit_ph;
        end
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int toggles, input bit jit, input int se0_bits);
        logic [1:0] lv;
        jit_ph = 0;
        lv     = LK;
        put(lv, jit);
        for (int i = 0; i < toggles; i++) begin
            lv = ~lv;
            put(lv, jit);
        end
        lv = LK;
        put(lv, jit);
        foreach (wbits[i]) begin
            if (!wbits[i]) lv = ~lv;
            put(lv, jit);
        end
        for (int i = 0; i < se0_bits; i++) put(LSE0, 0);
        for (int i = 0; i < 12; i++) put(LJ, 0);
    endtask

    task automatic run_pkt(input string tag, input int toggles, input bit stuff_en,
                           input int se0_bits, input bit jit);
        int         b_v, b_e, b_o, b_eo, b_a;
        logic [7:0] g;
        b_v  = n_valid;
        b_e  = n_err;
        b_o  = n_eop;
        b_eo = n_erreop;
        b_a  = n_act;
        build(stuff_en);
        model(se0_bits);
        send(toggles, jit, se0_bits);
        chk($sformatf("%s_nbytes", tag), n_valid - b_v, exp_q.size());
        foreach (exp_q[i]) begin
            g = (b_v + i < got_q.size()) ? got_q[b_v + i] : 8'hxx;
            chk($sformatf("%s_byte%0d", tag, i), g, exp_q[i]);
        end
        chk($sformatf("%s_err", tag), n_err - b_e, exp_err);
        chk($sformatf("%s_eop", tag), n_eop - b_o, 1);
        chk($sformatf("%s_err_with_eop", tag), n_erreop - b_eo, exp_erreop);
        chk($sformatf("%s_active", tag), (n_act - b_a) > 0, 1);
    endtask

    task automatic wait_valid(input int base, output bit ok);
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (n_valid > base) ok = 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         b_v, b_e, b_o, b_a;
        bit         ok;
        logic [7:0] b0;
        int         nb, extra, se0;

        rst   = 1;
        rx_en = 1;
        dp    = 1;
        dm    = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_line_state", line_state, LJ);
        chk("rst_rx_active", rxif.rx_active, 0);
        chk("rst_rx_valid", rxif.rx_valid, 0);
        chk("rst_rx_data", rxif.rx_data, 0);
        chk("rst_rx_err", rxif.rx_err, 0);
        chk("rst_eop", rxif.eop, 0);
        rst = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end

        lbits.delete();
        add_byte(8'hD2);
        run_pkt("ack", 6, 1, 2, 0);

        lbits.delete();
        add_byte(8'hC3); add_byte(8'hFF); add_byte(8'hFF); add_byte(8'h00);
        run_pkt("data0", 6, 1, 2, 0);

        lbits.delete();
        add_byte(8'h69);
        for (int i = 0; i < 7; i++) lbits.push_back(1'b1);
        lbits.push_back(1'b0); lbits.push_back(1'b1); lbits.push_back(1'b0);
        run_pkt("stuff_err", 6, 0, 2, 0);

        lbits.delete();
        add_byte(8'h2D);
        lbits.push_back(1'b1); lbits.push_back(1'b0); lbits.push_back(1'b1); lbits.push_back(1'b1);
        run_pkt("misalign", 6, 1, 2, 0);

        lbits.delete();
        add_byte(8'h4B);
        lbits.push_back(1'b0); lbits.push_back(1'b1);
        run_pkt("bus_reset", 6, 1, 12, 0);

        b_v = n_valid; b_o = n_eop; b_a = n_act;
        lbits.delete();
        build(1);
        send(2, 0, 2);
        chk("short_sync_active", n_act - b_a, 0);
        chk("short_sync_valid", n_valid - b_v, 0);
        chk("short_sync_eop", n_eop - b_o, 0);

        lbits.delete();
        add_byte(8'hA5);
        run_pkt("jitter", 6, 1, 2, 1);

        for (int r = 0; r < 12; r++) begin
            lbits.delete();
            nb = $urandom_range(1, 5);
            for (int j = 0; j < nb; j++) add_byte(8'($urandom));
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int j = 0; j < extra; j++) lbits.push_back(1'($urandom_range(0, 1)));
            se0 = ($urandom_range(0, 5) == 0) ? 12 : $urandom_range(1, 3);
            run_pkt($sformatf("rnd%0d", r), 2 * $urandom_range(2, 3),
                    ($urandom_range(0, 3) != 0), se0, 1'($urandom_range(0, 1)));
        end

        b_v = n_valid; b_e = n_err; b_o = n_eop;
        lbits.delete();
        b0 = 8'($urandom);
        add_byte(b0); add_byte(8'($urandom)); add_byte(8'($urandom));
        build(1);
        fork
            send(6, 0, 2);
            begin
                wait_valid(b_v, ok);
                chk("en_wait_valid", ok, 1);
                rx_en = 0;
                @(posedge clk);
                #1;
                chk("en_active_low", rxif.rx_active, 0);
            end
        join
        rx_en = 1;
        chk("en_nbytes", n_valid - b_v, 1);
        chk("en_byte0", (b_v < got_q.size()) ? got_q[b_v] : 8'hxx, b0);
        chk("en_eop", n_eop - b_o, 0);
        chk("en_err", n_err - b_e, 0);

        b_v = n_valid; b_e = n_err; b_o = n_eop;
        lbits.delete();
        add_byte(8'h55); add_byte(8'h00); add_byte(8'h00);
        build(1);
        fork
            send(6, 0, 2);
            begin
                wait_valid(b_v, ok);
                chk("rst_wait_valid", ok, 1);
                rst = 1;
                @(posedge clk);
                #1;
                chk("mid_rst_line_state", line_state, LJ);
                chk("mid_rst_rx_active", rxif.rx_active, 0);
                chk("mid_rst_rx_valid", rxif.rx_valid, 0);
                chk("mid_rst_rx_data", rxif.rx_data, 0);
                chk("mid_rst_rx_err", rxif.rx_err, 0);
                chk("mid_rst_eop", rxif.eop, 0);
                rst = 0;
            end
        join
        chk("mid_rst_nbytes", n_valid - b_v, 1);
        chk("mid_rst_byte0", (b_v < got_q.size()) ? got_q[b_v] : 8'hxx, 8'h55);
        chk("mid_rst_no_eop", n_eop - b_o, 0);
        chk("mid_rst_no_err", n_err - b_e, 0);

        chk("valid_eop_overlap", viol_ve, 0);
        chk("eop_active_fall", viol_eop, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/usb_fs_phy_rx.md
Name: usb_fs_phy_rx

Overview:
- Full-speed USB receive front end, clocked at 48 MHz (4x oversampling of the 12 Mb/s bit rate).
- Synchronises raw D+/D-, recovers bit timing and hunts for SYNC.
- Performs NRZI decode and bit unstuffing, assembles bytes LSB-first and detects EOP.
- Feeds the SIE receive path with a byte stream (rx_valid/rx_data) framed by rx_active.

Parameters:
- SYNC_MIN_TOGGLES, 3: minimum alternating K/J bits before the terminating KK that are accepted as SYNC (hubs may eat leading bits).
- SYNC_TIMEOUT_BITS, 16: bit times allowed in SYNC hunt without KK before returning to IDLE.
- SAMPLE_PHASE, 2: clocks after a resync edge at which the bit is sampled (0..3).

Ports:
- clk, input, 1: 48 MHz clock.
- rst, input, 1: synchronous active-high reset.
- dp_i, input, 1: raw D+ (asynchronous).
- dm_i, input, 1: raw D- (asynchronous).
- rx_en, input, 1: receive enable; low while the device transmits.
- line_state, output, 2: synchronised bus state, {dp,dm}: 2'b10=J, 2'b01=K, 2'b00=SE0, 2'b11=SE1.
- rx_active, output, 1: high from SYNC detect to EOP/abort.
- rx_valid, output, 1: one-cycle strobe, rx_data valid.
- rx_data, output, 8: received byte, LSB = first bit on wire.
- rx_err, output, 1: one-cycle strobe on stuff error, SE1, or non-byte-aligned EOP.
- eop, output, 1: one-cycle strobe at end of packet.

Behaviour:
- Reset values: all outputs 0, except line_state = 2'b10 (J). Also reset: FSM to IDLE, phase counter 0, previous level J, ones counter 0, bit counter 0.
- Input sync: dp_i/dm_i each pass 2 flops. line_state is the 2nd-flop value.
- Clock recovery:
  - 2-bit phase counter free-runs 0..3.
  - Any change of the synchronised differential value (J<->K or to/from SE0) reloads the counter to 0.
  - A bit is sampled when counter == SAMPLE_PHASE.
  - No-edge periods keep 4-clock spacing.
- NRZI decode: decoded bit = 1 if the sampled level equals the previous sampled level, 0 otherwise. The previous level is updated every sample.
- FSM states: IDLE, SYNC, DATA, EOP, ERR_WAIT.
  - IDLE: rx_active=0. First sampled K -> SYNC.
  - SYNC:
    - Count alternating samples.
    - Two consecutive K samples after >= SYNC_MIN_TOGGLES alternations -> DATA. rx_active rises the cycle after the second K sample. Bit/ones counters cleared.
    - KK too early, SE0, or SYNC_TIMEOUT_BITS bits elapsed -> IDLE, no strobes.
  - DATA:
    - Each sampled J/K produces a decoded bit.
    - Ones counter increments on 1 and clears on 0.
    - After 6 ones, the next bit is a stuff bit. If 0, it is dropped (not shifted, bit counter unchanged) and the ones counter clears. If 1: rx_err strobe -> ERR_WAIT.
    - Data bits shift into an 8-bit register from the MSB side (LSB-first wire order).
    - On the 8th bit: rx_data updated and rx_valid high on the clock after that sample point. Bit counter wraps to 0.
    - Ones count carries across byte boundaries.
    - Sampled SE0 -> EOP.
    - Sampled SE1 -> rx_err, ERR_WAIT.
  - EOP:
    - Wait for sampled J (SE0 of >= 1 bit accepted).
    - On J: eop strobe. rx_active falls in the same cycle. -> IDLE.
    - If the bit counter was non-zero at SE0 entry, rx_err strobes together with eop.
    - SE0 lasting > 8 bit times (bus reset) -> IDLE with eop strobe, no rx_err.
  - ERR_WAIT: rx_active stays 1. No rx_valid. Leave via SE0 then J, with eop strobe and rx_active fall; no second rx_err.
- rx_en low: FSM forced to IDLE next clock, rx_active=0. No eop and no rx_err are generated for the aborted packet. While low, SYNC hunting is suppressed; line_state keeps updating.
- rx_valid and eop never assert in the same cycle. A byte completing on the last bit before SE0 produces rx_valid, then eop later.
- Reset mid-packet: everything returns to reset values next clock. No strobes are emitted.

Test Plan:
- Drive SYNC (KJKJKJKK) + ACK PID 0xD2 + SE0 2 bits + J, at 4 clk/bit -> rx_active 1, exactly one rx_valid with rx_data=0xD2, then one eop, rx_err never set.
- DATA0 packet with bytes 0xC3, 0xFF, 0xFF, 0x00, stuff bits inserted by the stimulus -> four rx_valid strobes with exactly those values, no rx_err.
- Seven consecutive decoded 1s with no stuff bit after byte 0x69 -> one rx_err strobe, no further rx_valid, eop after the following SE0+J.
- Packet of 0x2D then 4 extra bits, then EOP -> one rx_valid (0x2D), rx_err and eop strobe in the same cycle.
- SYNC with only 2 leading toggles (KJKK) -> stays IDLE, no rx_active. Then SYNC with 6 toggles and bit edges alternating 3/5 clk spacing -> byte 0xA5 received correctly.
- rx_en dropped after 1 byte of a 3-byte packet -> rx_active 0 next clock, no eop or rx_err. Separately, rst during DATA -> all outputs at reset values next clock.
